// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider controller.
package div_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned FLAG_W = 3;

  // Bit positions inside resp_flags.
  localparam int unsigned FLAG_DBZ = 0;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_TMO = 2;

  localparam logic [DATA_W-1:0] INT16_MIN = 16'h8000;
  localparam logic [DATA_W-1:0] DBZ_QUOT  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic [FLAG_W-1:0] flags;
  } resp_t;

endpackage

// File: rtl/div_special_chk.sv
// Detects operand pairs the divider must not see and supplies their results.
module div_special_chk
  import div_pkg::*;
(
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              special_c,
  output resp_t             resp_c
);

  logic dbz;
  logic ovf;

  // Classify the operands and build the canned response.
  always_comb begin
    dbz       = (divisor == '0);
    ovf       = (dividend == INT16_MIN) && (divisor == DBZ_QUOT);
    special_c = dbz || ovf;
    resp_c    = '0;
    if (dbz) begin
      resp_c.quot            = DBZ_QUOT;
      resp_c.rem             = dividend;
      resp_c.flags[FLAG_DBZ] = 1'b1;
    end else if (ovf) begin
      resp_c.quot            = INT16_MIN;
      resp_c.rem             = '0;
      resp_c.flags[FLAG_OVF] = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Request/response front end that sequences an external 16-bit signed divider.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_dividend,
  input  logic [DATA_W-1:0] req_divisor,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_quotient,
  output logic [DATA_W-1:0] resp_remainder,
  output logic [TAG_W-1:0]  resp_tag,
  output logic [FLAG_W-1:0] resp_flags,
  output logic              div_start,
  output logic [DATA_W-1:0] div_dividend,
  output logic [DATA_W-1:0] div_divisor,
  input  logic [DATA_W-1:0] div_quotient,
  input  logic [DATA_W-1:0] div_remainder,
  input  logic              div_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  resp_t             resp_q, resp_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_d, resp_valid_d, div_start_d;
  logic              special_c;
  resp_t             sp_resp_c;
  logic              accept;
  logic              timeout;

  div_special_chk u_special_chk (
    .dividend  (req_dividend),
    .divisor   (req_divisor),
    .special_c (special_c),
    .resp_c    (sp_resp_c)
  );

  assign accept  = req_valid && req_ready;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and all registered outputs/datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      div_start  <= 1'b0;
      resp_q     <= '0;
      tag_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      div_start  <= div_start_d;
      resp_q     <= resp_d;
      tag_q      <= tag_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special_c ? S_RESP : S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (div_done || timeout) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    div_start_d  = (state_d == S_START);
    resp_d       = resp_q;
    tag_d        = tag_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cnt_d        = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          opa_d = req_dividend;
          opb_d = req_divisor;
          tag_d = req_tag;
          if (special_c) resp_d = sp_resp_c;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_done) begin
          resp_d.quot  = div_quotient;
          resp_d.rem   = div_remainder;
          resp_d.flags = '0;
        end else if (timeout) begin
          resp_d                 = '0;
          resp_d.flags[FLAG_TMO] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign resp_quotient  = resp_q.quot;
  assign resp_remainder = resp_q.rem;
  assign resp_flags     = resp_q.flags;
  assign resp_tag       = tag_q;
  assign div_dividend   = opa_q;
  assign div_divisor    = opb_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl with a behavioural divider.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_dividend, req_divisor;
  logic [3:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_quotient, resp_remainder;
  logic [3:0]  resp_tag;
  logic [2:0]  resp_flags;
  logic        div_start;
  logic [15:0] div_dividend, div_divisor;
  logic [15:0] div_quotient, div_remainder;
  logic        div_done;

  logic        model_done;
  logic        spurious_done;
  logic        never_done;
  logic        busy;
  logic [3:0]  lat;
  int          start_cnt = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.TIMEOUT_CYCLES(48)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dividend   (req_dividend),
    .req_divisor    (req_divisor),
    .req_tag        (req_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_quotient  (resp_quotient),
    .resp_remainder (resp_remainder),
    .resp_tag       (resp_tag),
    .resp_flags     (resp_flags),
    .div_start      (div_start),
    .div_dividend   (div_dividend),
    .div_divisor    (div_divisor),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_done       (div_done)
  );

  assign div_done = model_done | spurious_done;

  // Divider model: fixed latency, optional hang.
  always @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      lat        <= '0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (div_start) begin
        busy <= 1'b1;
        lat  <= 4'd3;
      end else if (busy) begin
        if (lat == 0) begin
          busy <= 1'b0;
          if (!never_done && div_divisor != 0) begin
            model_done    <= 1'b1;
            div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
            div_remainder <= $signed(div_dividend) % $signed(div_divisor);
          end
        end else begin
          lat <= lat - 4'd1;
        end
      end
    end
  end

  always @(posedge clk) if (div_start) start_cnt <= start_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] dd, input logic [15:0] ds, input logic [3:0] tg);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_dividend = dd; req_divisor = ds; req_tag = tg;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    total++;
    if (!req_ready) begin bad++; $display("FAIL send_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cycles, output logic prev_done);
    cycles = 0; prev_done = 1'b0;
    while (!resp_valid && cycles < 200) begin
      prev_done = div_done;
      @(negedge clk);
      cycles++;
    end
    total++;
    if (!resp_valid) begin bad++; $display("FAIL resp_wait got=%b exp=1", resp_valid); end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (div_start !== 1'b0) begin bad++; $display("FAIL reset_div_start got=%b exp=0", div_start); end
    total++;
    if ({resp_quotient, resp_remainder, resp_tag, resp_flags} !== 39'd0) begin
      bad++; $display("FAIL reset_resp got=%h/%h/%h/%h exp=0", resp_quotient, resp_remainder, resp_tag, resp_flags);
    end
  endtask

  task automatic test_normal();
    logic [15:0] dd [3] = '{16'd100, 16'hFF9C, 16'd100};
    logic [15:0] ds [3] = '{16'd7, 16'd7, 16'hFFF9};
    logic [15:0] eq [3] = '{16'd14, 16'hFFF2, 16'hFFF2};
    logic [15:0] er [3] = '{16'd2, 16'hFFFE, 16'd2};
    logic [3:0]  et [3] = '{4'd3, 4'd4, 4'd5};
    int   cyc;
    int   s0;
    logic pd;
    for (int i = 0; i < 3; i++) begin
      s0 = start_cnt;
      send(dd[i], ds[i], et[i]);
      wait_resp(cyc, pd);
      total++; if (resp_quotient !== eq[i]) begin bad++; $display("FAIL norm%0d_q got=%h exp=%h", i, resp_quotient, eq[i]); end
      total++; if (resp_remainder !== er[i]) begin bad++; $display("FAIL norm%0d_r got=%h exp=%h", i, resp_remainder, er[i]); end
      total++; if (resp_flags !== 3'b000) begin bad++; $display("FAIL norm%0d_flags got=%b exp=000", i, resp_flags); end
      total++; if (resp_tag !== et[i]) begin bad++; $display("FAIL norm%0d_tag got=%h exp=%h", i, resp_tag, et[i]); end
      total++; if (pd !== 1'b1) begin bad++; $display("FAIL norm%0d_latency got=%b exp=1", i, pd); end
      total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL norm%0d_starts got=%0d exp=1", i, start_cnt - s0); end
      take_resp();
    end
  endtask

  task automatic test_special();
    int s0;
    s0 = start_cnt;
    send(16'd5, 16'd0, 4'd7);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL dbz_latency got=%b exp=1", resp_valid); end
    total++; if (resp_quotient !== 16'hFFFF) begin bad++; $display("FAIL dbz_q got=%h exp=ffff", resp_quotient); end
    total++; if (resp_remainder !== 16'd5) begin bad++; $display("FAIL dbz_r got=%h exp=0005", resp_remainder); end
    total++; if (resp_flags !== 3'b001) begin bad++; $display("FAIL dbz_flags got=%b exp=001", resp_flags); end
    total++; if (resp_tag !== 4'd7) begin bad++; $display("FAIL dbz_tag got=%h exp=7", resp_tag); end
    take_resp();
    send(16'h8000, 16'hFFFF, 4'd8);
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL ovf_latency got=%b exp=1", resp_valid); end
    total++; if (resp_quotient !== 16'h8000) begin bad++; $display("FAIL ovf_q got=%h exp=8000", resp_quotient); end
    total++; if (resp_remainder !== 16'd0) begin bad++; $display("FAIL ovf_r got=%h exp=0000", resp_remainder); end
    total++; if (resp_flags !== 3'b010) begin bad++; $display("FAIL ovf_flags got=%b exp=010", resp_flags); end
    take_resp();
    total++; if (start_cnt != s0) begin bad++; $display("FAIL special_starts got=%0d exp=0", start_cnt - s0); end
  endtask

  task automatic test_backpressure();
    int   cyc;
    logic pd;
    send(16'd100, 16'd7, 4'd1);
    wait_resp(cyc, pd);
    req_valid = 1'b1; req_dividend = 16'd50; req_divisor = 16'd3; req_tag = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_quotient !== 16'd14 || resp_remainder !== 16'd2 ||
          resp_tag !== 4'd1 || resp_flags !== 3'b000) begin
        bad++; $display("FAIL bp_stable%0d got=%b/%h/%h/%h/%b exp=1/000e/0002/1/000", i,
                        resp_valid, resp_quotient, resp_remainder, resp_tag, resp_flags);
      end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready%0d got=%b exp=0", i, req_ready); end
    end
    take_resp();
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_resp_drop got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b exp=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b exp=0", req_ready); end
    wait_resp(cyc, pd);
    total++; if (resp_quotient !== 16'd16) begin bad++; $display("FAIL bp2_q got=%h exp=0010", resp_quotient); end
    total++; if (resp_remainder !== 16'd2) begin bad++; $display("FAIL bp2_r got=%h exp=0002", resp_remainder); end
    total++; if (resp_tag !== 4'd9) begin bad++; $display("FAIL bp2_tag got=%h exp=9", resp_tag); end
    take_resp();
  endtask

  task automatic test_timeout();
    int   cyc;
    logic pd;
    never_done = 1'b1;
    send(16'd7, 16'd2, 4'd6);
    wait_resp(cyc, pd);
    total++; if (cyc != 49) begin bad++; $display("FAIL tmo_cycles got=%0d exp=49", cyc); end
    total++; if (resp_flags !== 3'b100) begin bad++; $display("FAIL tmo_flags got=%b exp=100", resp_flags); end
    total++; if (resp_quotient !== 16'd0 || resp_remainder !== 16'd0) begin
      bad++; $display("FAIL tmo_qr got=%h/%h exp=0000/0000", resp_quotient, resp_remainder);
    end
    total++; if (resp_tag !== 4'd6) begin bad++; $display("FAIL tmo_tag got=%h exp=6", resp_tag); end
    take_resp();
    never_done = 1'b0;
    spurious_done = 1'b1;
    repeat (2) @(negedge clk);
    spurious_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL spurious%0d got=%b/%b exp=0/1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int   cyc;
    logic pd;
    never_done = 1'b1;
    send(16'd9, 16'd3, 4'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_resp got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_ready got=%b exp=1", req_ready); end
    never_done = 1'b0;
    send(16'd1000, 16'd10, 4'd11);
    wait_resp(cyc, pd);
    total++; if (resp_quotient !== 16'd100) begin bad++; $display("FAIL post_rst_q got=%h exp=0064", resp_quotient); end
    total++; if (resp_remainder !== 16'd0) begin bad++; $display("FAIL post_rst_r got=%h exp=0000", resp_remainder); end
    total++; if (resp_tag !== 4'd11) begin bad++; $display("FAIL post_rst_tag got=%h exp=b", resp_tag); end
    take_resp();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; req_tag = '0;
    resp_ready = 1'b0; spurious_done = 1'b0; never_done = 1'b0;
    div_quotient = '0; div_remainder = '0;
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
